icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 18 +
 rtl/icache_if.sv | 25 ++
 rtl/icache_array.sv | 36 +++
 rtl/icache.sv | 127 ++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: bus widths,
// geometry and the byte-address split.
package icache_pkg;

   localparam int ICACHE_INST_W   = 32;
   localparam int ICACHE_ADDR_W   = 17;
   localparam int ICACHE_INDEX_W  = 7;
   localparam int ICACHE_OFFSET_W = 2;
   localparam int ICACHE_TAG_W    = ICACHE_ADDR_W - ICACHE_INDEX_W - ICACHE_OFFSET_W;
   localparam int ICACHE_LINES    = 1 << ICACHE_INDEX_W;

   typedef logic [ICACHE_INST_W-1:0] inst_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
      return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-stage <-> instruction cache bus: read request/response, fill, flush.
interface icache_if import icache_pkg::*; #(
   parameter int ADDR_W = ICACHE_ADDR_W
) ();

   logic              read_i;
   logic [ADDR_W-1:0] read_addr_i;
   logic              read_hit_o;
   inst_t             read_inst_o;
   logic              write_i;
   logic [ADDR_W-1:0] write_addr_i;
   inst_t             write_inst_i;
   logic              flush_i;

   modport master (
      output read_i, read_addr_i, write_i, write_addr_i, write_inst_i, flush_i,
      input  read_hit_o, read_inst_o
   );

   modport slave (
      input  read_i, read_addr_i, write_i, write_addr_i, write_inst_i, flush_i,
      output read_hit_o, read_inst_o
   );

endinterface

// File: rtl/icache_array.sv
// Tag + instruction storage: one write port, one registered read port.
// No reset so the array can map onto a RAM macro.
module icache_array import icache_pkg::*; #(
   parameter int INDEX_W = ICACHE_INDEX_W,
   parameter int TAG_W   = ICACHE_TAG_W
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] waddr_i,
   input  logic [TAG_W-1:0]   wtag_i,
   input  inst_t              wdata_i,
   input  logic               re_i,
   input  logic [INDEX_W-1:0] raddr_i,
   output logic [TAG_W-1:0]   rtag_o,
   output inst_t              rdata_o
);

   localparam int LINES = 1 << INDEX_W;
   localparam int WORD_W = TAG_W + ICACHE_INST_W;

   logic [WORD_W-1:0] mem_q [LINES];
   logic [WORD_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= {wtag_i, wdata_i};
      end
      if (re_i) begin
         rd_q <= mem_q[raddr_i];
      end
   end

   assign rtag_o  = rd_q[WORD_W-1:ICACHE_INST_W];
   assign rdata_o = rd_q[ICACHE_INST_W-1:0];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache with 1-cycle read, write-first
// forwarding and single-cycle flush. ICACHE_STATS_EN adds hit/miss counters.
module icache import icache_pkg::*; #(
   parameter int INDEX_W = ICACHE_INDEX_W,
   parameter int ADDR_W  = ICACHE_ADDR_W
) (
   input  logic        clk,
   input  logic        rst,
   icache_if.slave     bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
`endif
);

   localparam int TAG_W = ADDR_W - INDEX_W - ICACHE_OFFSET_W;
   localparam int LINES = 1 << INDEX_W;

   logic [INDEX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0]   rd_tag, wr_tag;
   logic               wr_en;

   logic [LINES-1:0]   valid_q, valid_d;
   logic               rd_req_q, rd_req_d;
   logic               line_vld_q, line_vld_d;
   logic               fwd_q, fwd_d;
   logic [TAG_W-1:0]   req_tag_q, req_tag_d;
   logic [TAG_W-1:0]   fwd_tag_q, fwd_tag_d;
   inst_t              fwd_data_q, fwd_data_d;

   logic [TAG_W-1:0]   arr_tag, sel_tag;
   inst_t              arr_data, sel_data;
   logic               hit;
   logic               unused_offset;

   assign rd_idx = bus.read_addr_i[INDEX_W+1:2];
   assign rd_tag = bus.read_addr_i[ADDR_W-1:INDEX_W+2];
   assign wr_idx = bus.write_addr_i[INDEX_W+1:2];
   assign wr_tag = bus.write_addr_i[ADDR_W-1:INDEX_W+2];
   assign unused_offset = ^{bus.read_addr_i[1:0], bus.write_addr_i[1:0]};

   // Flush wins over a simultaneous fill; the fill never reaches the array.
   assign wr_en = bus.write_i & ~bus.flush_i;

   icache_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_array (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_idx),
      .wtag_i  (wr_tag),
      .wdata_i (bus.write_inst_i),
      .re_i    (bus.read_i),
      .raddr_i (rd_idx),
      .rtag_o  (arr_tag),
      .rdata_o (arr_data)
   );

   always_comb begin
      valid_d = valid_q;
      if (bus.flush_i) begin
         valid_d = '0;
      end else if (bus.write_i) begin
         valid_d[wr_idx] = 1'b1;
      end
      rd_req_d   = bus.read_i & ~bus.flush_i;
      line_vld_d = valid_q[rd_idx];
      fwd_d      = wr_en & bus.read_i & (wr_idx == rd_idx);
      req_tag_d  = rd_tag;
      fwd_tag_d  = wr_tag;
      fwd_data_d = bus.write_inst_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= '0;
         rd_req_q   <= 1'b0;
         line_vld_q <= 1'b0;
         fwd_q      <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         rd_req_q   <= rd_req_d;
         line_vld_q <= line_vld_d;
         fwd_q      <= fwd_d;
      end
   end

   always_ff @(posedge clk) begin
      req_tag_q  <= req_tag_d;
      fwd_tag_q  <= fwd_tag_d;
      fwd_data_q <= fwd_data_d;
   end

   // A same-index fill in the request cycle overrides the stale array read.
   assign sel_tag  = fwd_q ? fwd_tag_q  : arr_tag;
   assign sel_data = fwd_q ? fwd_data_q : arr_data;
   assign hit      = rd_req_q & (fwd_q | line_vld_q) & (sel_tag == req_tag_q);

   assign bus.read_hit_o  = hit;
   assign bus.read_inst_o = hit ? sel_data : '0;

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = sat_inc(hit_cnt_q, rd_req_q & hit);
      miss_cnt_d = sat_inc(miss_cnt_q, rd_req_q & ~hit);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
